// File: rtl/qar_mem_arbiter.sv
// Two-master to one-slave memory arbiter for qar_core: data bus has priority,
// fetch is protected by a burst limit, and a watchdog completes dead transactions.
module qar_mem_arbiter #(
  parameter int                    ADDR_WIDTH     = 32,
  parameter int                    DATA_WIDTH     = 32,
  parameter int                    MAX_DATA_BURST = 4,
  parameter int                    TIMEOUT_CYCLES = 64,
  parameter logic [DATA_WIDTH-1:0] ERR_RDATA      = 32'hDEAD_BEEF
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  imem_valid,
  input  logic [ADDR_WIDTH-1:0] imem_addr,
  output logic                  imem_ready,
  output logic [DATA_WIDTH-1:0] imem_rdata,
  input  logic                  mem_valid,
  input  logic                  mem_we,
  input  logic [ADDR_WIDTH-1:0] mem_addr,
  input  logic [DATA_WIDTH-1:0] mem_wdata,
  output logic                  mem_ready,
  output logic [DATA_WIDTH-1:0] mem_rdata,
  output logic                  m_valid,
  output logic                  m_we,
  output logic [ADDR_WIDTH-1:0] m_addr,
  output logic [DATA_WIDTH-1:0] m_wdata,
  input  logic                  m_ready,
  input  logic [DATA_WIDTH-1:0] m_rdata,
  output logic                  bus_err,
  output logic                  grant_d
);

  localparam int BW = $clog2(MAX_DATA_BURST + 1);
  localparam int TW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    BUSY_I = 2'd1,
    BUSY_D = 2'd2
  } state_t;

  state_t                state_q, state_d;
  logic [ADDR_WIDTH-1:0] m_addr_q;
  logic                  m_we_q;
  logic [DATA_WIDTH-1:0] m_wdata_q;
  logic [BW-1:0]         burst_cnt_q;
  logic [TW-1:0]         tmo_cnt_q;
  logic                  grant_d_q;

  logic                  busy;
  logic                  burst_ok;
  logic                  grant_data;
  logic                  grant_fetch;
  logic                  tmo_last;
  logic                  tmo_hit;
  logic                  done;
  logic                  complete;
  logic [DATA_WIDTH-1:0] rdata_sel;

  // Handshake: each side holds valid until its single-cycle ready; the
  // downstream side holds m_valid and the request fields until m_ready.
  assign busy        = (state_q != IDLE);
  assign burst_ok    = (burst_cnt_q < BW'(MAX_DATA_BURST));
  assign grant_data  = mem_valid && (!imem_valid || burst_ok);
  assign grant_fetch = imem_valid && !grant_data;
  assign tmo_last    = (tmo_cnt_q == TW'(TIMEOUT_CYCLES - 1));
  // m_ready beats the watchdog when both land in the same cycle.
  assign tmo_hit     = busy && tmo_last && !m_ready;
  assign done        = busy && (m_ready || tmo_hit);
  assign complete    = done && !rst;
  assign rdata_sel   = m_ready ? m_rdata : ERR_RDATA;

  // State register
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE: begin
        if (grant_data) begin
          state_d = BUSY_D;
        end else if (grant_fetch) begin
          state_d = BUSY_I;
        end
      end
      BUSY_I, BUSY_D: begin
        if (done) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Grant datapath, burst limiter and watchdog counter
  always_ff @(posedge clk) begin
    if (rst) begin
      m_addr_q    <= '0;
      m_we_q      <= 1'b0;
      m_wdata_q   <= '0;
      burst_cnt_q <= '0;
      tmo_cnt_q   <= '0;
      grant_d_q   <= 1'b0;
    end else begin
      if (state_q == IDLE) begin
        tmo_cnt_q <= '0;
        if (grant_data) begin
          m_addr_q  <= mem_addr;
          m_we_q    <= mem_we;
          m_wdata_q <= mem_wdata;
          grant_d_q <= 1'b1;
          if (!imem_valid) begin
            burst_cnt_q <= '0;
          end else if (burst_ok) begin
            burst_cnt_q <= burst_cnt_q + BW'(1);
          end
        end else if (grant_fetch) begin
          m_addr_q    <= imem_addr;
          m_we_q      <= 1'b0;
          m_wdata_q   <= '0;
          grant_d_q   <= 1'b0;
          burst_cnt_q <= '0;
        end
      end else if (!m_ready && !tmo_last) begin
        tmo_cnt_q <= tmo_cnt_q + TW'(1);
      end
    end
  end

  // Output logic: completion is a combinational pass-through of the slave
  always_comb begin
    m_valid    = busy;
    imem_ready = 1'b0;
    imem_rdata = '0;
    mem_ready  = 1'b0;
    mem_rdata  = '0;
    bus_err    = tmo_hit && !rst;
    unique case (state_q)
      BUSY_I: begin
        imem_ready = complete;
        imem_rdata = complete ? rdata_sel : '0;
      end
      BUSY_D: begin
        mem_ready = complete;
        mem_rdata = complete ? rdata_sel : '0;
      end
      default: ;
    endcase
  end

  assign m_we    = m_we_q;
  assign m_addr  = m_addr_q;
  assign m_wdata = m_wdata_q;
  assign grant_d = grant_d_q;

endmodule

// File: tb/tb_qar_mem_arbiter.sv
// Directed bench for qar_mem_arbiter: fetch, data write/read, contention,
// watchdog timeout, timeout/ack race and reset in the middle of a transaction.
module tb_qar_mem_arbiter;

  logic        clk;
  logic        rst;
  logic        imem_valid;
  logic [31:0] imem_addr;
  logic        imem_ready;
  logic [31:0] imem_rdata;
  logic        mem_valid;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic        mem_ready;
  logic [31:0] mem_rdata;
  logic        m_valid;
  logic        m_we;
  logic [31:0] m_addr;
  logic [31:0] m_wdata;
  logic        m_ready;
  logic [31:0] m_rdata;
  logic        bus_err;
  logic        grant_d;

  int checks   = 0;
  int failures = 0;

  logic [31:0] slave_mem [logic [31:0]];

  qar_mem_arbiter dut (
    .clk        (clk),
    .rst        (rst),
    .imem_valid (imem_valid),
    .imem_addr  (imem_addr),
    .imem_ready (imem_ready),
    .imem_rdata (imem_rdata),
    .mem_valid  (mem_valid),
    .mem_we     (mem_we),
    .mem_addr   (mem_addr),
    .mem_wdata  (mem_wdata),
    .mem_ready  (mem_ready),
    .mem_rdata  (mem_rdata),
    .m_valid    (m_valid),
    .m_we       (m_we),
    .m_addr     (m_addr),
    .m_wdata    (m_wdata),
    .m_ready    (m_ready),
    .m_rdata    (m_rdata),
    .bus_err    (bus_err),
    .grant_d    (grant_d)
  );

  // Clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic apply_reset();
    rst        = 1'b1;
    imem_valid = 1'b0;
    imem_addr  = '0;
    mem_valid  = 1'b0;
    mem_we     = 1'b0;
    mem_addr   = '0;
    mem_wdata  = '0;
    m_ready    = 1'b0;
    m_rdata    = '0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
  endtask

  // Slave driver: acks on the ack_at-th cycle of m_valid (0 = never) and
  // reports what the arbiter presented and returned. Inputs are driven 1ns
  // after posedge and outputs sampled on negedge; returns 1ns after the posedge
  // that ends the completion cycle, with gap_mv = m_valid in that next cycle.
  task automatic serve(input int ack_at, input logic [31:0] rd,
                       output int rcyc, output bit got_i, output bit got_d,
                       output logic [31:0] got_rdata, output bit got_err,
                       output logic [31:0] got_addr, output logic got_we,
                       output logic [31:0] got_wdata, output int wait_cyc,
                       output bit leak, output logic gap_mv);
    int c = 0;
    rcyc = -1; got_i = 0; got_d = 0; got_rdata = '0; got_err = 0;
    got_addr = '0; got_we = 1'bx; got_wdata = '0; wait_cyc = -1; leak = 0;
    for (int n = 1; n <= 200; n++) begin
      @(posedge clk); #1;
      m_ready = 1'b0;
      m_rdata = 32'h1234_5678;
      if (m_valid) begin
        c++;
        if (c == 1) begin
          got_addr = m_addr; got_we = m_we; got_wdata = m_wdata; wait_cyc = n;
        end
        if (c == ack_at) begin
          m_ready = 1'b1;
          if (m_we) begin
            slave_mem[m_addr] = m_wdata;
            m_rdata = '0;
          end else begin
            m_rdata = slave_mem.exists(m_addr) ? slave_mem[m_addr] : rd;
          end
        end
      end
      @(negedge clk);
      if (!imem_ready && imem_rdata !== '0) leak = 1;
      if (!mem_ready && mem_rdata !== '0) leak = 1;
      if (imem_ready || mem_ready) begin
        rcyc = c; got_i = imem_ready; got_d = mem_ready;
        got_rdata = imem_ready ? imem_rdata : mem_rdata; got_err = bus_err;
        break;
      end
    end
    @(posedge clk); #1;
    m_ready = 1'b0;
    m_rdata = '0;
    gap_mv  = m_valid;
  endtask

  int          rcyc, wcyc;
  bit          gi, gd, gerr, leak;
  logic [31:0] grd, gaddr, gwd;
  logic        gwe, gmv;

  task automatic test_reset();
    rst = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    checks++;
    if ({m_valid, m_we, imem_ready, mem_ready, bus_err, grant_d} !== 6'b0) begin
      failures++;
      $display("FAIL reset_ctrl got=%b exp=000000",
               {m_valid, m_we, imem_ready, mem_ready, bus_err, grant_d});
    end
    checks++;
    if (m_addr !== 32'h0 || m_wdata !== 32'h0) begin
      failures++;
      $display("FAIL reset_bus addr=%h wdata=%h exp=0/0", m_addr, m_wdata);
    end
    checks++;
    if (imem_rdata !== 32'h0 || mem_rdata !== 32'h0) begin
      failures++;
      $display("FAIL reset_rdata i=%h d=%h exp=0/0", imem_rdata, mem_rdata);
    end
    @(posedge clk); #1 rst = 1'b0;
  endtask

  task automatic test_fetch();
    imem_valid = 1'b1;
    imem_addr  = 32'h10;
    serve(2, 32'h0050_0093, rcyc, gi, gd, grd, gerr, gaddr, gwe, gwd, wcyc, leak, gmv);
    imem_valid = 1'b0;
    // request cycle, m_valid cycle, then ack cycle: ready in the 3rd cycle
    checks++;
    if (wcyc !== 1 || rcyc !== 2) begin
      failures++;
      $display("FAIL fetch_latency wait=%0d ack_cyc=%0d exp=1/2", wcyc, rcyc);
    end
    checks++;
    if (gi !== 1'b1 || gd !== 1'b0 || grd !== 32'h0050_0093) begin
      failures++;
      $display("FAIL fetch_resp i=%b d=%b rdata=%h exp=1/0/00500093", gi, gd, grd);
    end
    checks++;
    if (gaddr !== 32'h10 || gwe !== 1'b0 || gwd !== 32'h0) begin
      failures++;
      $display("FAIL fetch_req addr=%h we=%b wdata=%h exp=10/0/0", gaddr, gwe, gwd);
    end
    checks++;
    if (leak !== 1'b0 || gmv !== 1'b0 || grant_d !== 1'b0) begin
      failures++;
      $display("FAIL fetch_misc leak=%b gap_mv=%b grant_d=%b exp=0/0/0", leak, gmv, grant_d);
    end
  endtask

  task automatic test_write_read();
    mem_valid = 1'b1;
    mem_we    = 1'b1;
    mem_addr  = 32'h40;
    mem_wdata = 32'hCAFE_BABE;
    serve(1, 32'h0, rcyc, gi, gd, grd, gerr, gaddr, gwe, gwd, wcyc, leak, gmv);
    checks++;
    if (gwe !== 1'b1 || gwd !== 32'hCAFE_BABE || gaddr !== 32'h40) begin
      failures++;
      $display("FAIL wr_req we=%b wdata=%h addr=%h exp=1/cafebabe/40", gwe, gwd, gaddr);
    end
    checks++;
    if (gd !== 1'b1 || gi !== 1'b0 || rcyc !== 1 || wcyc !== 1) begin
      failures++;
      $display("FAIL wr_resp d=%b i=%b ack_cyc=%0d wait=%0d exp=1/0/1/1", gd, gi, rcyc, wcyc);
    end
    checks++;
    if (gmv !== 1'b0 || grant_d !== 1'b1) begin
      failures++;
      $display("FAIL wr_gap m_valid=%b grant_d=%b exp=0/1", gmv, grant_d);
    end
    mem_we    = 1'b0;
    mem_wdata = 32'h0;
    serve(1, 32'h0, rcyc, gi, gd, grd, gerr, gaddr, gwe, gwd, wcyc, leak, gmv);
    mem_valid = 1'b0;
    // one low m_valid cycle (the IDLE cycle) between the two transactions
    checks++;
    if (wcyc !== 1 || gwe !== 1'b0) begin
      failures++;
      $display("FAIL rd_gap wait=%0d we=%b exp=1/0", wcyc, gwe);
    end
    checks++;
    if (gd !== 1'b1 || grd !== 32'hCAFE_BABE || gerr !== 1'b0 || leak !== 1'b0) begin
      failures++;
      $display("FAIL rd_resp d=%b rdata=%h err=%b leak=%b exp=1/cafebabe/0/0", gd, grd, gerr, leak);
    end
  endtask

  task automatic test_contention();
    logic [9:0] exp_order;
    logic [9:0] got_order;
    exp_order = 10'b1111011110;  // bit 9 first: D,D,D,D,I,D,D,D,D,I
    got_order = '0;
    apply_reset();
    imem_valid = 1'b1; imem_addr = 32'h100;
    mem_valid  = 1'b1; mem_we = 1'b0; mem_addr = 32'h200;
    for (int t = 0; t < 10; t++) begin
      serve(1, 32'h0, rcyc, gi, gd, grd, gerr, gaddr, gwe, gwd, wcyc, leak, gmv);
      got_order[9-t] = gd;
      checks++;
      if (gd !== exp_order[9-t] || gi !== !exp_order[9-t]) begin
        failures++;
        $display("FAIL contention_grant%0d d=%b i=%b exp_d=%b", t, gd, gi, exp_order[9-t]);
      end
      if (gd) mem_addr = mem_addr + 32'h4;
      else imem_addr = imem_addr + 32'h4;
    end
    imem_valid = 1'b0;
    mem_valid  = 1'b0;
  endtask

  task automatic test_timeout();
    mem_valid = 1'b1; mem_we = 1'b0; mem_addr = 32'h44;
    serve(0, 32'h0, rcyc, gi, gd, grd, gerr, gaddr, gwe, gwd, wcyc, leak, gmv);
    mem_valid = 1'b0;
    checks++;
    if (rcyc !== 64 || gd !== 1'b1 || gerr !== 1'b1) begin
      failures++;
      $display("FAIL tmo_pulse cyc=%0d d=%b err=%b exp=64/1/1", rcyc, gd, gerr);
    end
    checks++;
    if (grd !== 32'hDEAD_BEEF || leak !== 1'b0 || gmv !== 1'b0) begin
      failures++;
      $display("FAIL tmo_data rdata=%h leak=%b gap_mv=%b exp=deadbeef/0/0", grd, leak, gmv);
    end
    imem_valid = 1'b1; imem_addr = 32'h20;
    serve(2, 32'h0000_0013, rcyc, gi, gd, grd, gerr, gaddr, gwe, gwd, wcyc, leak, gmv);
    imem_valid = 1'b0;
    checks++;
    if (gi !== 1'b1 || grd !== 32'h0000_0013 || gerr !== 1'b0 || rcyc !== 2 || gaddr !== 32'h20) begin
      failures++;
      $display("FAIL tmo_recover i=%b rdata=%h err=%b cyc=%0d addr=%h exp=1/00000013/0/2/20",
               gi, grd, gerr, rcyc, gaddr);
    end
  endtask

  task automatic test_race();
    mem_valid = 1'b1; mem_we = 1'b0; mem_addr = 32'h48;
    serve(64, 32'h0BAD_F00D, rcyc, gi, gd, grd, gerr, gaddr, gwe, gwd, wcyc, leak, gmv);
    mem_valid = 1'b0;
    checks++;
    if (rcyc !== 64 || gd !== 1'b1 || gerr !== 1'b0 || grd !== 32'h0BAD_F00D) begin
      failures++;
      $display("FAIL race cyc=%0d d=%b err=%b rdata=%h exp=64/1/0/0badf00d", rcyc, gd, gerr, grd);
    end
  endtask

  task automatic test_reset_mid();
    int n;
    mem_valid = 1'b1; mem_we = 1'b1; mem_addr = 32'h80; mem_wdata = 32'h5A5A_5A5A;
    n = 0;
    while (!m_valid && n < 10) begin
      @(posedge clk); #1; n++;
    end
    checks++;
    if (m_valid !== 1'b1 || grant_d !== 1'b1 || m_addr !== 32'h80) begin
      failures++;
      $display("FAIL rstmid_busy m_valid=%b grant_d=%b addr=%h exp=1/1/80", m_valid, grant_d, m_addr);
    end
    rst = 1'b1; mem_valid = 1'b0; m_ready = 1'b1; m_rdata = 32'h55;
    @(negedge clk);
    checks++;
    if (mem_ready !== 1'b0 || imem_ready !== 1'b0 || bus_err !== 1'b0) begin
      failures++;
      $display("FAIL rstmid_noready d=%b i=%b err=%b exp=0/0/0", mem_ready, imem_ready, bus_err);
    end
    @(posedge clk); #1;
    m_ready = 1'b0; m_rdata = '0;
    checks++;
    if ({m_valid, m_we, grant_d, mem_ready} !== 4'b0 || m_addr !== 32'h0 || m_wdata !== 32'h0) begin
      failures++;
      $display("FAIL rstmid_clear ctl=%b addr=%h wdata=%h exp=0000/0/0",
               {m_valid, m_we, grant_d, mem_ready}, m_addr, m_wdata);
    end
    rst = 1'b0;
    imem_valid = 1'b1; imem_addr = 32'h30;
    serve(1, 32'h0010_0073, rcyc, gi, gd, grd, gerr, gaddr, gwe, gwd, wcyc, leak, gmv);
    imem_valid = 1'b0;
    checks++;
    if (gi !== 1'b1 || grd !== 32'h0010_0073 || rcyc !== 1 || wcyc !== 1) begin
      failures++;
      $display("FAIL rstmid_fetch i=%b rdata=%h cyc=%0d wait=%0d exp=1/00100073/1/1", gi, grd, rcyc, wcyc);
    end
  endtask

  initial begin
    apply_reset();
    test_reset();
    test_fetch();
    test_write_read();
    test_contention();
    test_timeout();
    test_race();
    test_reset_mid();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
